// File: rtl/spi_pattern_gen_if.sv
// Purpose: bundles the pattern generator's control and FIFO-write signals.
// Latency: none, wires only.
// Backpressure: full from the TX FIFO stalls the producer; wr is only ever high while full is low.
// Ports (master = generator side):
//   start  / frames : run request and frame count, into the generator
//   busy   / done   : run status, out of the generator
//   wdata  / wr     : FIFO write data and strobe, out of the generator
//   full            : FIFO full, into the generator
interface spi_pattern_gen_if #(
  parameter int DATA = 8
);
  logic            start;
  logic [7:0]      frames;
  logic            busy;
  logic            done;
  logic [DATA-1:0] wdata;
  logic            wr;
  logic            full;

  modport master (
    input  start, frames, full,
    output busy, done, wdata, wr
  );

  modport slave (
    output start, frames, full,
    input  busy, done, wdata, wr
  );
endinterface

// File: rtl/spi_pattern_gen.sv
// Purpose: writes N frames of the byte ramp FIRST..FIRST+LEN-1 into the SPI TX FIFO for loopback bring-up.
// Latency: first write one cycle after start is accepted; LEN cycles per frame with full low, then GAP idle cycles.
// Backpressure: wr = WRITE && !full, so a full cycle simply holds idx/wdata; nothing is lost or repeated.
// Ports: clk, rst (synchronous, active-low), bus (spi_pattern_gen_if.master:
//   start, frames, busy, done, wdata, wr, full).
// Option: SPI_PATGEN_CRC_EN appends a CRC-8 (poly 0x07, init 0) byte after each frame's data bytes.
module spi_pattern_gen #(
  parameter int              DATA  = 8,
  parameter logic [DATA-1:0] FIRST = DATA'(8'h31),
  parameter int              LEN   = 9,
  parameter int              GAP   = 0
) (
  input  logic                clk,
  input  logic                rst,
  spi_pattern_gen_if.master   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

`ifdef SPI_PATGEN_CRC_EN
  // The CRC byte sits at idx==LEN, one slot past the last data byte.
  localparam logic [7:0] LAST_IDX = 8'(LEN);
  localparam logic [7:0] DATA_END = 8'(LEN - 1);
`else
  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
`endif

  logic [1:0]      state;
  logic [7:0]      idx;
  logic [7:0]      fcnt;
  logic [7:0]      gcnt;
  logic [DATA-1:0] wdata_q;
  logic            wr;

  assign wr        = (state == S_WRITE) && !bus.full;
  assign bus.wr    = wr;
  assign bus.wdata = wdata_q;
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = (state == S_DONE);

`ifdef SPI_PATGEN_CRC_EN
  logic [7:0] crc;
  logic [7:0] crc_nxt;

  // MSB-first CRC-8, whole byte folded in, then eight shift/reduce steps.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign crc_nxt = crc8_byte(crc, wdata_q[7:0]);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      fcnt    <= '0;
      gcnt    <= '0;
      wdata_q <= '0;
`ifdef SPI_PATGEN_CRC_EN
      crc     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.frames != 8'd0) begin
              state   <= S_WRITE;
              fcnt    <= bus.frames;
              idx     <= '0;
              wdata_q <= FIRST;
`ifdef SPI_PATGEN_CRC_EN
              crc     <= '0;
`endif
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_WRITE: begin
          if (wr) begin
            if (idx == LAST_IDX) begin
              if (fcnt == 8'd1) begin
                state <= S_DONE;
              end else begin
                fcnt <= fcnt - 8'd1;
                if (GAP > 0) begin
                  state <= S_GAP;
                  gcnt  <= '0;
                end else begin
                  idx     <= '0;
                  wdata_q <= FIRST;
`ifdef SPI_PATGEN_CRC_EN
                  crc     <= '0;
`endif
                end
              end
            end else begin
              idx <= idx + 8'd1;
`ifdef SPI_PATGEN_CRC_EN
              crc <= crc_nxt;
              // After the last data byte the next word is the finished CRC.
              if (idx == DATA_END) begin
                wdata_q <= crc_nxt;
              end else begin
                wdata_q <= FIRST + DATA'(idx + 8'd1);
              end
`else
              wdata_q <= FIRST + DATA'(idx + 8'd1);
`endif
            end
          end
        end

        S_GAP: begin
          if (gcnt == GAP_M1) begin
            state   <= S_WRITE;
            idx     <= '0;
            wdata_q <= FIRST;
`ifdef SPI_PATGEN_CRC_EN
            crc     <= '0;
`endif
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pattern_gen.sv
module tb_spi_pattern_gen;

  localparam int         LEN   = 9;
  localparam logic [7:0] FIRST = 8'h31;
`ifdef SPI_PATGEN_CRC_EN
  localparam int NB = LEN + 1;
`else
  localparam int NB = LEN;
`endif

  logic clk;
  logic rst;

  spi_pattern_gen_if #(.DATA(8)) bus0 ();
  spi_pattern_gen_if #(.DATA(8)) bus1 ();

  spi_pattern_gen #(.DATA(8), .FIRST(8'h31), .LEN(LEN), .GAP(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  spi_pattern_gen #(.DATA(8), .FIRST(8'h31), .LEN(LEN), .GAP(2)) dut_g (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  int wcnt0  = 0;
  int wcnt1  = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC, clocked in one data bit at a time.
  function automatic logic [7:0] crc_ref(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic push_frame(input int sel, input int nbytes);
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = FIRST + 8'(i);
      c = crc_ref(c, b);
      if (sel == 0) q0.push_back(b); else q1.push_back(b);
    end
`ifdef SPI_PATGEN_CRC_EN
    if (nbytes == LEN) begin
      if (sel == 0) q0.push_back(c); else q1.push_back(c);
    end
`endif
  endtask

  // Scoreboards: every write strobe must match the head of its queue.
  always @(negedge clk) begin
    if (bus0.wr === 1'b1) begin
      wcnt0++;
      chk("wr0_expected", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) chk("wdata0", {24'd0, bus0.wdata}, {24'd0, q0.pop_front()});
    end
    if (bus1.wr === 1'b1) begin
      wcnt1++;
      chk("wr1_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) chk("wdata1", {24'd0, bus1.wdata}, {24'd0, q1.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Pulse start for one edge; afterwards we sit in relative cycle 1.
  task automatic do_start(input int sel, input logic [7:0] nfr);
    if (sel == 0) begin bus0.start = 1'b1; bus0.frames = nfr; end
    else          begin bus1.start = 1'b1; bus1.frames = nfr; end
    tick();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int sel, input int limit, output int rel);
    rel = -1;
    for (int i = 0; i < limit; i++) begin
      if ((sel == 0 && bus0.done === 1'b1) || (sel == 1 && bus1.done === 1'b1)) begin
        rel = cyc - t0 + 1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int rel;
    rst = 1'b0;
    bus0.start = 1'b0; bus0.frames = 8'd0; bus0.full = 1'b0;
    bus1.start = 1'b0; bus1.frames = 8'd0; bus1.full = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy",  32'(bus0.busy),  32'd0);
    chk("rst_done",  32'(bus0.done),  32'd0);
    chk("rst_wr",    32'(bus0.wr),    32'd0);
    chk("rst_wdata", 32'(bus0.wdata), 32'd0);
    rst = 1'b1;
    tick();

    // 1: single frame, no backpressure
    push_frame(0, LEN);
    do_start(0, 8'd1);
    for (int r = 1; r <= NB; r++) begin
      chk("t1_wr",   32'(bus0.wr),   32'd1);
      chk("t1_busy", 32'(bus0.busy), 32'd1);
      chk("t1_done", 32'(bus0.done), 32'd0);
      tick();
    end
    chk("t1_done_at", 32'(bus0.done), 32'd1);
    chk("t1_busy_at", 32'(bus0.busy), 32'd1);
    chk("t1_wr_at",   32'(bus0.wr),   32'd0);
    tick();
    chk("t1_done_end", 32'(bus0.done), 32'd0);
    chk("t1_busy_end", 32'(bus0.busy), 32'd0);
    chk("t1_q_empty",  32'(q0.size()), 32'd0);
    chk("t1_wcnt",     32'(wcnt0),     32'(NB));

    // 2: full held for the three cycles that would write 33..35
    push_frame(0, LEN);
    do_start(0, 8'd1);
    tick(); tick();
    bus0.full = 1'b1;
    for (int r = 0; r < 3; r++) begin
      #1;
      chk("t2_wr_full", 32'(bus0.wr), 32'd0);
      tick();
    end
    bus0.full = 1'b0;
    wait_done(0, 40, rel);
    chk("t2_done_rel", 32'(rel), 32'(NB + 4));
    tick();
    chk("t2_q_empty", 32'(q0.size()), 32'd0);

    // 2b: full on the final word only delays done by one cycle
    push_frame(0, LEN);
    do_start(0, 8'd1);
    for (int r = 1; r < NB; r++) tick();
    bus0.full = 1'b1;
    #1;
    chk("t2b_wr_last_full", 32'(bus0.wr), 32'd0);
    tick();
    bus0.full = 1'b0;
    #1;
    chk("t2b_no_early_done", 32'(bus0.done), 32'd0);
    chk("t2b_wr_last",       32'(bus0.wr),   32'd1);
    wait_done(0, 40, rel);
    chk("t2b_done_rel", 32'(rel), 32'(NB + 2));
    tick();
    chk("t2b_q_empty", 32'(q0.size()), 32'd0);

    // 3: three frames with a 2-cycle gap
    for (int f = 0; f < 3; f++) push_frame(1, LEN);
    do_start(1, 8'd3);
    for (int r = 1; r < 3 * NB + 5; r++) begin
      chk("t3_wr_pattern", 32'(bus1.wr), 32'(((r - 1) % (NB + 2)) < NB));
      tick();
    end
    chk("t3_done_at", 32'(bus1.done), 32'd1);
    tick();
    chk("t3_wcnt",    32'(wcnt1),     32'(3 * NB));
    chk("t3_q_empty", 32'(q1.size()), 32'd0);
    chk("t3_idle",    32'(bus1.busy), 32'd0);

    // 4: zero frames, then a start pulse while busy
    do_start(0, 8'd0);
    chk("t4_done0", 32'(bus0.done), 32'd1);
    chk("t4_busy0", 32'(bus0.busy), 32'd1);
    chk("t4_wr0",   32'(bus0.wr),   32'd0);
    tick();
    chk("t4_idle0", 32'(bus0.done), 32'd0);
    wcnt0 = 0;
    push_frame(0, LEN);
    do_start(0, 8'd1);
    tick();
    bus0.start = 1'b1; bus0.frames = 8'd5;
    tick();
    bus0.start = 1'b0;
    wait_done(0, 40, rel);
    chk("t4_done_rel", 32'(rel), 32'(NB + 1));
    tick(); tick(); tick();
    chk("t4_busy_end", 32'(bus0.busy), 32'd0);
    chk("t4_wcnt",     32'(wcnt0),     32'(NB));
    chk("t4_q_empty",  32'(q0.size()), 32'd0);

    // 5: reset after the fourth byte, then restart from FIRST
    push_frame(0, 4);
    do_start(0, 8'd2);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("t5_wr",    32'(bus0.wr),    32'd0);
    chk("t5_busy",  32'(bus0.busy),  32'd0);
    chk("t5_done",  32'(bus0.done),  32'd0);
    chk("t5_wdata", 32'(bus0.wdata), 32'd0);
    chk("t5_q_empty_abort", 32'(q0.size()), 32'd0);
    rst = 1'b1;
    tick();
    push_frame(0, LEN);
    do_start(0, 8'd1);
    chk("t5_restart_wdata", 32'(bus0.wdata), 32'(FIRST));
    wait_done(0, 40, rel);
    chk("t5_done_rel", 32'(rel), 32'(NB + 1));
    tick();
    chk("t5_q_empty", 32'(q0.size()), 32'd0);

    // 6: two frames back to back (CRC byte included when enabled)
    wcnt0 = 0;
    push_frame(0, LEN);
    push_frame(0, LEN);
    do_start(0, 8'd2);
    wait_done(0, 80, rel);
    chk("t6_done_rel", 32'(rel), 32'(2 * NB + 1));
    tick();
    chk("t6_wcnt",    32'(wcnt0),     32'(2 * NB));
    chk("t6_q_empty", 32'(q0.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
